// File: rtl/tmr_voter_monitor.sv
// Registered majority voter and health monitor for the SR/JK/T flip-flop trio.
// Each enabled sample is voted. Every source's disagreement is filtered by a run
// counter, and a sticky fault flag sets after PERSIST consecutive disagreements.
// The block also keeps a saturating disagreement count and a 4-state health summary.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   OK       | no fault flags, last sample agreed
//   SUSPECT  | no fault flags, last sample had a disagreeing source
//   DEGRADED | exactly one source flagged faulty
//   FAIL     | two or more sources flagged; vote frozen until clear/reset
module tmr_voter_monitor #(
  parameter int CNT_W   = 8,
  parameter int PERSIST = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             clear_err_i,
  input  logic             q_sr_i,
  input  logic             q_jk_i,
  input  logic             q_t_i,
  output logic             q_vote_o,
  output logic             disagree_o,
  output logic             fault_sr_o,
  output logic             fault_jk_o,
  output logic             fault_t_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [1:0]       state_o
);

  localparam int RUN_W = (PERSIST < 1) ? 1 : $clog2(PERSIST + 1);
  // A run counter equal to this value means the current disagreement is the PERSIST-th.
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(PERSIST - 1);

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_SUSPECT  = 2'd1,
    ST_DEGRADED = 2'd2,
    ST_FAIL     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             vote_q, vote_d;
  logic             dis_q, dis_d;
  logic [2:0]       fault_q, fault_d;
  logic [RUN_W-1:0] run_q [3];
  logic [RUN_W-1:0] run_d [3];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0] src;
  logic       maj;
  logic       dis_now;
  logic       fault_multi;
  logic       fault_any;

  // Bit 0 is SR, bit 1 is JK, bit 2 is T, matching fault_q.
  assign src     = {q_t_i, q_jk_i, q_sr_i};
  assign maj     = (q_sr_i & q_jk_i) | (q_sr_i & q_t_i) | (q_jk_i & q_t_i);
  assign dis_now = ~(&src) & (|src);

  // Next-state, vote and monitor bookkeeping for one sample.
  always_comb begin
    state_d     = state_q;
    vote_d      = vote_q;
    dis_d       = dis_q;
    fault_d     = fault_q;
    cnt_d       = cnt_q;
    run_d       = run_q;
    fault_multi = 1'b0;
    fault_any   = 1'b0;
    if (clear_err_i) begin
      state_d = ST_OK;
      dis_d   = 1'b0;
      fault_d = '0;
      cnt_d   = '0;
      for (int i = 0; i < 3; i++) run_d[i] = '0;
      if (en_i) vote_d = maj;
    end else if (en_i) begin
      dis_d = dis_now;
      if (dis_now && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
      // A flagged source's counter is frozen; the flag alone carries the verdict.
      for (int i = 0; i < 3; i++) begin
        if (!fault_q[i]) begin
          if (src[i] != maj) begin
            run_d[i] = run_q[i] + 1'b1;
            if (run_q[i] == RUN_LAST) fault_d[i] = 1'b1;
          end else begin
            run_d[i] = '0;
          end
        end
      end
      if (state_q != ST_FAIL) vote_d = maj;
      fault_multi = (fault_d[0] & fault_d[1]) | (fault_d[0] & fault_d[2]) |
                    (fault_d[1] & fault_d[2]);
      fault_any   = |fault_d;
      if ((state_q == ST_FAIL) || fault_multi) state_d = ST_FAIL;
      else if (fault_any)                      state_d = ST_DEGRADED;
      else if (dis_now)                        state_d = ST_SUSPECT;
      else                                     state_d = ST_OK;
    end
  end

  // State and monitor registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_OK;
      vote_q  <= 1'b0;
      dis_q   <= 1'b0;
      fault_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < 3; i++) run_q[i] <= '0;
    end else begin
      state_q <= state_d;
      vote_q  <= vote_d;
      dis_q   <= dis_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < 3; i++) run_q[i] <= run_d[i];
    end
  end

  assign q_vote_o    = vote_q;
  assign disagree_o  = dis_q;
  assign fault_sr_o  = fault_q[0];
  assign fault_jk_o  = fault_q[1];
  assign fault_t_o   = fault_q[2];
  assign err_count_o = cnt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_tmr_voter_monitor.sv
// Bench for tmr_voter_monitor. Two instances share the same stimulus:
// dut0 uses the defaults (CNT_W=8, PERSIST=3), and dut1 uses CNT_W=2, PERSIST=1.
// A behavioural model is compared against both instances after every edge.
module tb_tmr_voter_monitor;

  logic clk;
  logic rst, en, clr, sr, jk, t;

  logic       qv0, dis0, fsr0, fjk0, ft0;
  logic [7:0] cnt0;
  logic [1:0] st0;
  logic       qv1, dis1, fsr1, fjk1, ft1;
  logic [1:0] cnt1;
  logic [1:0] st1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // model state, index 0 = dut0, 1 = dut1
  int P    [2] = '{3, 1};
  int CMAX [2] = '{255, 3};
  int m_vote [2];
  int m_dis  [2];
  int m_cnt  [2];
  int m_st   [2];
  int m_flag [2][3];
  int m_run  [2][3];

  tmr_voter_monitor #(.CNT_W(8), .PERSIST(3)) dut0 (
    .clk_i(clk), .reset_i(rst), .en_i(en), .clear_err_i(clr),
    .q_sr_i(sr), .q_jk_i(jk), .q_t_i(t),
    .q_vote_o(qv0), .disagree_o(dis0), .fault_sr_o(fsr0), .fault_jk_o(fjk0),
    .fault_t_o(ft0), .err_count_o(cnt0), .state_o(st0)
  );

  tmr_voter_monitor #(.CNT_W(2), .PERSIST(1)) dut1 (
    .clk_i(clk), .reset_i(rst), .en_i(en), .clear_err_i(clr),
    .q_sr_i(sr), .q_jk_i(jk), .q_t_i(t),
    .q_vote_o(qv1), .disagree_o(dis1), .fault_sr_o(fsr1), .fault_jk_o(fjk1),
    .fault_t_o(ft1), .err_count_o(cnt1), .state_o(st1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Reference behaviour for one clock edge, applied to both model instances.
  task automatic model_edge();
    int s [3];
    int sum, maj, dis, nf;
    s[0] = int'(sr); s[1] = int'(jk); s[2] = int'(t);
    sum = s[0] + s[1] + s[2];
    maj = (sum >= 2) ? 1 : 0;
    dis = (sum == 1 || sum == 2) ? 1 : 0;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_vote[d] = 0; m_dis[d] = 0; m_cnt[d] = 0; m_st[d] = 0;
        for (int i = 0; i < 3; i++) begin m_flag[d][i] = 0; m_run[d][i] = 0; end
      end else if (clr) begin
        m_dis[d] = 0; m_cnt[d] = 0; m_st[d] = 0;
        for (int i = 0; i < 3; i++) begin m_flag[d][i] = 0; m_run[d][i] = 0; end
        if (en) m_vote[d] = maj;
      end else if (en) begin
        m_dis[d] = dis;
        if (dis == 1 && m_cnt[d] < CMAX[d]) m_cnt[d]++;
        for (int i = 0; i < 3; i++) begin
          if (m_flag[d][i] == 0) begin
            if (s[i] != maj) begin
              m_run[d][i]++;
              if (m_run[d][i] >= P[d]) m_flag[d][i] = 1;
            end else begin
              m_run[d][i] = 0;
            end
          end
        end
        if (m_st[d] != 3) m_vote[d] = maj;
        nf = m_flag[d][0] + m_flag[d][1] + m_flag[d][2];
        if (m_st[d] == 3 || nf >= 2) m_st[d] = 3;
        else if (nf == 1)            m_st[d] = 2;
        else if (dis == 1)           m_st[d] = 1;
        else                         m_st[d] = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("d0 q_vote",   int'(qv0),  m_vote[0]);
    chk("d0 disagree", int'(dis0), m_dis[0]);
    chk("d0 fault_sr", int'(fsr0), m_flag[0][0]);
    chk("d0 fault_jk", int'(fjk0), m_flag[0][1]);
    chk("d0 fault_t",  int'(ft0),  m_flag[0][2]);
    chk("d0 err_count", int'(cnt0), m_cnt[0]);
    chk("d0 state",    int'(st0),  m_st[0]);
    chk("d1 q_vote",   int'(qv1),  m_vote[1]);
    chk("d1 disagree", int'(dis1), m_dis[1]);
    chk("d1 fault_sr", int'(fsr1), m_flag[1][0]);
    chk("d1 fault_jk", int'(fjk1), m_flag[1][1]);
    chk("d1 fault_t",  int'(ft1),  m_flag[1][2]);
    chk("d1 err_count", int'(cnt1), m_cnt[1]);
    chk("d1 state",    int'(st1),  m_st[1]);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic r, input logic e, input logic c,
                       input logic a, input logic b, input logic z);
    rst = r; en = e; clr = c; sr = a; jk = b; t = z;
  endtask

  int victim;

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    // reset, then agreement
    repeat (2) step();
    chk("reset q_vote", int'(qv0), 0);
    chk("reset state", int'(st0), 0);
    drive(0, 1, 0, 1, 1, 1);
    step();
    chk("agree q_vote", int'(qv0), 1);
    chk("agree state", int'(st0), 0);
    repeat (3) step();

    // glitch below persistence
    drive(0, 1, 0, 1, 0, 1);
    repeat (2) step();
    chk("glitch state", int'(st0), 1);
    drive(0, 1, 0, 1, 1, 1);
    step();
    chk("glitch err_count", int'(cnt0), 2);
    chk("glitch fault_jk", int'(fjk0), 0);
    chk("glitch state back", int'(st0), 0);

    // persistent jk fault, then t fault
    drive(0, 1, 0, 1, 0, 1);
    repeat (3) step();
    chk("jk fault flag", int'(fjk0), 1);
    chk("jk fault state", int'(st0), 2);
    drive(0, 1, 0, 1, 1, 0);
    repeat (3) step();
    chk("t fault flag", int'(ft0), 1);
    chk("fail state", int'(st0), 3);
    drive(0, 1, 0, 0, 0, 0);
    step();
    chk("fail vote frozen", int'(qv0), 1);

    // clear versus sample
    drive(0, 1, 1, 0, 0, 0);
    step();
    chk("clear state", int'(st0), 0);
    chk("clear err_count", int'(cnt0), 0);
    chk("clear q_vote", int'(qv0), 0);

    // en gating
    drive(0, 1, 0, 1, 0, 1);
    repeat (2) step();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 1'($urandom), 1'($urandom), 1'($urandom));
      step();
    end
    chk("gap fault_jk", int'(fjk0), 0);
    drive(0, 1, 0, 1, 0, 1);
    step();
    chk("gated fault_jk", int'(fjk0), 1);

    // saturation of the 2-bit counter
    drive(0, 0, 1, 0, 0, 0);
    step();
    drive(0, 1, 0, 1, 0, 1);
    repeat (6) step();
    chk("saturated err_count", int'(cnt1), 3);

    // reset beats clear and enable
    drive(1, 1, 1, 1, 1, 1);
    step();
    chk("mid reset q_vote", int'(qv0), 0);
    chk("mid reset state", int'(st0), 0);
    chk("mid reset err_count", int'(cnt0), 0);

    // randomized phase
    victim = 3;
    for (int k = 0; k < 3000; k++) begin
      logic base;
      int dev;
      if ($urandom_range(0, 11) == 0) victim = $urandom_range(0, 3);
      base = 1'($urandom);
      dev = ($urandom_range(0, 3) != 0) ? victim : 3;
      rst = ($urandom_range(0, 299) == 0);
      clr = ($urandom_range(0, 79) == 0);
      en  = ($urandom_range(0, 7) != 0);
      sr  = base ^ (dev == 0);
      jk  = base ^ (dev == 1);
      t   = base ^ (dev == 2);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tmr_voter_monitor.md
# tmr_voter_monitor

Registered majority voter and health monitor that sits directly downstream of the three-way D flip-flop stage (SR-, JK- and T-based implementations of the same D input). It consumes the three flip-flop outputs each sampling cycle and produces one voted bit. It also tracks per-implementation disagreement with persistence filtering, latches sticky fault flags, and keeps a saturating disagreement counter.

## Interface
- `CNT_W`, default 8: width of `err_count`.
- `PERSIST`, default 3: consecutive disagreeing samples needed to declare a source faulty. Legal range is PERSIST ≥ 1.

- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high reset.
- `en`  input  1  sample enable. Inputs are evaluated only when `en`=1.
- `clear_err`  input  1  synchronous clear of the fault, count and state logic.
- `q_sr`, `q_jk`, `q_t`  input  1 each  flip-flop outputs under test.
- `q_vote`  output  1  registered majority value.
- `disagree`  output  1  registered. High if the last sample had any input differing from the majority.
- `fault_sr`, `fault_jk`, `fault_t`  output  1 each  sticky per-source fault flags.
- `err_count`  output  CNT_W  saturating count of disagreeing samples.
- `state`  output  2  monitor state: 0=OK, 1=SUSPECT, 2=DEGRADED, 3=FAIL.

## Operation
- Majority is maj = (sr&jk)|(sr&t)|(jk&t). With three inputs, at most one source disagrees in any sample.
- **Sample rule (`en`=1, `clear_err`=0):**
  - `disagree` is loaded with (the sample's inputs are not all equal).
  - `err_count` increments by 1 when the sample disagrees, and holds at all-ones once saturated.
  - Each source has a run counter, width $clog2(PERSIST+1).
    - The counter increments when that source ≠ maj.
    - The counter resets to 0 when that source = maj.
    - When the counter reaches PERSIST, the source's fault flag sets. The flag is sticky and the counter stops.
  - `q_vote` is loaded with maj, except in FAIL, where `q_vote` holds its last value.
- **Next state** is computed from the next-cycle fault flags and the current sample:
  - Two or more flags set → FAIL.
  - Exactly one flag set → DEGRADED.
  - Otherwise, the current sample disagrees → SUSPECT.
  - Otherwise → OK.
  - FAIL is absorbing until `clear_err` or `reset`.
- **`en`=0:** every register holds, including `disagree`.
- **`clear_err`=1:**
  - Resets fault flags, run counters, `err_count`, `disagree` and `state` (to OK).
  - `q_vote` is not cleared. If `en`=1 in the same cycle, `q_vote` loads maj; otherwise it holds.
  - `clear_err` has priority over the sample rule for all cleared registers.
- **`reset`=1:** all outputs go to 0 (`q_vote`=0, `disagree`=0, all fault flags 0, `err_count`=0, `state`=OK). `reset` has priority over `clear_err` and `en`.

## Timing
- All outputs are registered. Latency is 1 cycle: a sample taken at edge N is reflected at every output after edge N.
- Fault detection latency: a source that disagrees on PERSIST consecutive enabled samples has its flag high after the PERSIST-th of those edges.
- Run counters count enabled samples only. `en`=0 gaps neither advance nor reset them.
- A reset asserted mid-run, including in FAIL, takes effect at the next edge. The first sample after reset deasserts is evaluated normally.
- No combinational path exists from any input to any output.

## Test plan
- **Reset and agreement.** Hold `reset` for 2 cycles, then drive sr=jk=t=1 with `en`=1 for 4 cycles.
  - During reset all outputs are 0 and `state`=0.
  - After the first sample: `q_vote`=1, `disagree`=0, `state`=OK, `err_count`=0.
- **Glitch below persistence** (PERSIST=3). Drive jk=0 for 2 enabled cycles with sr=t=1, then jk=1.
  - `q_vote` stays 1 and `disagree` is 1 for 2 cycles.
  - `state` goes SUSPECT, then returns to OK.
  - `err_count`=2 and `fault_jk`=0.
- **Persistent fault, then second fault.** Drive jk≠maj for 3 samples.
  - After the 3rd edge, `fault_jk`=1 and `state`=DEGRADED.
  - Then drive t≠maj for 3 samples. After the 3rd edge, `fault_t`=1, `state`=FAIL, and `q_vote` is frozen even when inputs change.
- **`en` gating.** Start a jk disagreement run of 2 samples, hold `en`=0 for 5 cycles, then give 1 more disagreeing sample.
  - All outputs hold during the gap.
  - `fault_jk` sets on the 3rd enabled sample.
- **Saturation** (CNT_W=2). Apply 6 disagreeing samples.
  - `err_count` counts 1, 2, 3, then stays at 3.
- **Clear versus sample.** From FAIL, assert `clear_err` with `en`=1 and inputs sr=jk=t=0 in the same cycle.
  - Next cycle: flags 0, `err_count`=0, `state`=OK, `disagree`=0, `q_vote`=0.
- **Reset mid-operation.** Assert `reset` while `clear_err` and `en` are both high.
  - All outputs are 0 on the following cycle.
